// File: rtl/mux16_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux16_rr_arbiter
// Round-robin arbiter that shares one mux16to1 datapath among 16 requesters.
// It picks one requester, drives the 4-bit mux select, holds a one-hot grant
// until release, and inserts a one-cycle gap between owners so the mux output
// can settle before the next owner uses it.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   : a grant is revoked after MAX_HOLD cycles and timeout pulses
//   undefined : a grant holds until done or the owner's req drops; timeout = 0
//
// Parameters
//   MAX_HOLD  maximum grant length in cycles (2..255), timeout build only
//
// Ports
//   clk      in   1   clock, rising edge
//   rst      in   1   synchronous active-high reset
//   req      in   16  level-sensitive request per channel
//   done     in   1   current owner releases the grant (1-cycle pulse)
//   sel      out  4   mux select, index of current/last owner
//   gnt      out  16  one-hot grant, zero when no owner
//   busy     out  1   high while granting or in the settle gap
//   timeout  out  1   1-cycle pulse when MAX_HOLD revokes a grant
// ---------------------------------------------------------------------------
module mux16_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        busy,
  output logic        timeout
);

  localparam int unsigned N  = 16;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 8;

  // Reject out-of-range hold limits at elaboration.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux16_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q,   gnt_d;
  logic [SW-1:0]   sel_q,   sel_d;
  logic [SW-1:0]   ptr_q,   ptr_d;
  logic            busy_q,  busy_d;

  logic            win_found_c;
  logic [SW-1:0]   win_idx_c;
  logic [SW-1:0]   cand_c;
  logic            hold_exp_c;
  logic            owner_req_c;

`ifdef ARB_TIMEOUT_EN
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  // Last cycle the current owner is allowed to keep the grant.
  assign hold_exp_c = (cnt_q == CW'(MAX_HOLD - 1));
`else
  assign hold_exp_c = 1'b0;
`endif

  assign owner_req_c = req[sel_q];

  // Rotating priority search: first set request after ptr, wrapping mod 16.
  // The 4-bit sum wraps naturally, so i=16 lands back on ptr itself.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand_c      = '0;
    for (int i = 1; i <= N; i++) begin
      cand_c = ptr_q + SW'(i);
      if (!win_found_c && req[cand_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (win_found_c) begin
          state_d          = S_GRANT;
          gnt_d[win_idx_c] = 1'b1;
          sel_d            = win_idx_c;
          ptr_d            = win_idx_c;
          busy_d           = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d            = '0;
`endif
        end
      end

      S_GRANT: begin
        // Other requesters are ignored here; only the owner can end the grant.
        if (done || !owner_req_c || hold_exp_c) begin
          state_d = S_GAP;
          gnt_d   = '0;
          busy_d  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          // Only a pure hold-limit release is reported as a timeout.
          timeout_d = hold_exp_c && !done && owner_req_c;
`endif
        end
`ifdef ARB_TIMEOUT_EN
        if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end

      S_GAP: begin
        // Settle cycle: sel stays on the previous owner.
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; ptr resets to 15 so channel 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= SW'(N - 1);
      busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: behavioural phase/owner model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mux16_rr_arbiter;

  localparam int unsigned MAXH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        done = 1'b0;
  logic [15:0] req  = 16'h0;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        busy;
  logic        timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  mux16_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: phase 0 = no owner, 1 = owner holds grant, 2 = settle gap.
  int m_phase = 0;
  int m_owner = 0;
  int m_last  = 15;
  int m_held  = 0;
  int m_c     = 0;
  bit m_to    = 1'b0;
  bit m_valid = 1'b0;
  bit m_found = 1'b0;
  bit by_done, by_drop, by_time;

  always @(posedge clk) begin
    cyc++;
    m_to = 1'b0;
    if (rst) begin
      m_phase = 0;
      m_owner = 0;
      m_last  = 15;
      m_held  = 0;
      m_valid = 1'b1;
    end else if (m_phase == 0) begin
      m_found = 1'b0;
      for (int d = 1; d <= 16; d++) begin
        m_c = (m_last + d) % 16;
        if (!m_found && req[m_c]) begin
          m_found = 1'b1;
          m_owner = m_c;
        end
      end
      if (m_found) begin
        m_last  = m_owner;
        m_phase = 1;
        m_held  = 0;
      end
    end else if (m_phase == 1) begin
      by_done = done;
      by_drop = !req[m_owner];
      by_time = TO_EN && (m_held == int'(MAXH) - 1);
      if (by_done || by_drop || by_time) begin
        m_phase = 2;
        m_to    = by_time && !by_done && !by_drop;
      end else if (m_held < 255) begin
        m_held++;
      end
    end else begin
      m_phase = 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("gnt",     32'(gnt),     (m_phase == 1) ? (32'd1 << m_owner) : 32'd0);
      chk("sel",     32'(sel),     32'(m_owner));
      chk("busy",    32'(busy),    32'(m_phase != 0));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("onehot0", 32'($onehot0(gnt)), 32'd1);
    end
  end

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!ok) begin
        if (gnt != 16'h0) ok = 1'b1;
        else @(negedge clk);
      end
    end
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    bit ok;
    int t_first;
    int n;
    t_first = 0;

    // Reset with every channel requesting.
    rst = 1'b1; req = 16'hFFFF; done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt",  32'(gnt),  32'h0);
    chk("rst_sel",  32'(sel),  32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_gnt", 32'(gnt), 32'h0001);
    chk("first_sel", 32'(sel), 32'h0);

    // Full rotation 0..15 then wrap to 0.
    for (int g = 0; g < 17; g++) begin
      wait_gnt(ok);
      chk("rr_wait", 32'(ok), 32'd1);
      chk("rr_sel", 32'(sel), 32'(g % 16));
      if (g == 0) t_first = cyc;
      if (g == 1) chk("rr_spacing", 32'(cyc - t_first), 32'd3);
      pulse_done();
    end

    // Wrap-around from ptr=14.
    req = 16'h4000;
    wait_gnt(ok); chk("wrap_wait0", 32'(ok), 32'd1);
    chk("wrap_sel14a", 32'(sel), 32'd14);
    pulse_done();
    req = 16'h4001;
    wait_gnt(ok); chk("wrap_wait1", 32'(ok), 32'd1);
    chk("wrap_sel0", 32'(sel), 32'd0);
    chk("wrap_gnt0", 32'(gnt), 32'h0001);
    pulse_done();
    wait_gnt(ok); chk("wrap_wait2", 32'(ok), 32'd1);
    chk("wrap_sel14b", 32'(sel), 32'd14);
    pulse_done();
    req = 16'h0;
    @(negedge clk);

    // Release by dropping the owner's request.
    req = 16'h0020;
    wait_gnt(ok); chk("drop_wait", 32'(ok), 32'd1);
    chk("drop_gnt", 32'(gnt), 32'h0020);
    repeat (3) @(negedge clk);
    chk("drop_hold", 32'(gnt), 32'h0020);
    req = 16'h0;
    @(negedge clk);
    chk("drop_gap_gnt",  32'(gnt),  32'h0);
    chk("drop_gap_busy", 32'(busy), 32'd1);
    chk("drop_gap_sel",  32'(sel),  32'd5);
    @(negedge clk);
    chk("drop_idle_busy", 32'(busy), 32'd0);
    pulse_done();
    chk("idle_done_gnt", 32'(gnt), 32'h0);

    // Hold-limit behaviour.
    req = 16'h0008;
    wait_gnt(ok); chk("to_wait", 32'(ok), 32'd1);
    chk("to_gnt", 32'(gnt), 32'h0008);
`ifdef ARB_TIMEOUT_EN
    for (n = 0; n < 20 && gnt != 16'h0; n++) @(negedge clk);
    chk("to_len",   32'(n),       32'd4);
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_busy",  32'(busy),    32'd1);
    @(negedge clk);
    chk("to_pulse_end", 32'(timeout), 32'd0);
    chk("to_idle_gnt",  32'(gnt),     32'h0);
    @(negedge clk);
    chk("to_regrant", 32'(gnt), 32'h0008);
    repeat (3) @(negedge clk);
    pulse_done();
    chk("to_with_done", 32'(timeout), 32'd0);
    chk("to_with_done_gnt", 32'(gnt), 32'h0);
`else
    n = 0;
    repeat (10) @(negedge clk);
    chk("noto_hold",  32'(gnt),     32'h0008);
    chk("noto_pulse", 32'(timeout), 32'd0);
`endif
    req = 16'h0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a grant.
    req = 16'h0200;
    wait_gnt(ok); chk("mr_wait", 32'(ok), 32'd1);
    chk("mr_sel", 32'(sel), 32'd9);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_gnt",  32'(gnt),  32'h0);
    chk("mr_sel0", 32'(sel),  32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    req = 16'h0600;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_regrant", 32'(gnt), 32'h0200);
    chk("mr_resel",   32'(sel), 32'd9);
    req = 16'h0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
